// File: rtl/mem_stage_if.sv
// EX->MEM->WB bus of the memory stage. The slave modport is the stage itself;
// the master modport is whatever drives EX, stall/flush and the SRAM read port.
interface mem_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic [2:0]  ex_load_op;
  logic [31:0] data_sram_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        mem_adel;
  logic [37:0] mem_to_id;

  modport slave (
    input  stall_i, flush_i, ex_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_load_op,
    input  data_sram_rdata,
    output wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, mem_adel, mem_to_id
  );

  modport master (
    output stall_i, flush_i, ex_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_load_op,
    output data_sram_rdata,
    input  wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, mem_adel, mem_to_id
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: holds the EX result for one cycle, aligns load data from
// the data SRAM, flags misaligned loads and feeds WB plus the ID bypass bus.
// SRAM read data is only valid in the first cycle a load sits in MEM, so it is
// buffered when that cycle is stalled.
module mem_stage (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);

  localparam logic [2:0] LdLb  = 3'd1;
  localparam logic [2:0] LdLbu = 3'd2;
  localparam logic [2:0] LdLh  = 3'd3;
  localparam logic [2:0] LdLhu = 3'd4;
  localparam logic [2:0] LdLw  = 3'd5;

  logic        mem_valid_q;
  logic [31:0] mem_pc_q;
  logic        mem_rf_we_q;
  logic [4:0]  mem_rf_waddr_q;
  logic [31:0] mem_result_q;
  logic [2:0]  mem_load_op_q;
  logic [1:0]  mem_addr_lo_q;
  logic        fresh_q;
  logic [31:0] buf_q;
  logic        buf_valid_q;

  logic        load_en;
  logic [31:0] raw_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] aligned;
  logic        adel;
  logic        we_eff;

  assign load_en = ~bus.stall_i & ~bus.flush_i;

  // MEM register: a flush wipes the whole entry so WB and the bypass bus read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q    <= 1'b0;
      mem_pc_q       <= '0;
      mem_rf_we_q    <= 1'b0;
      mem_rf_waddr_q <= '0;
      mem_result_q   <= '0;
      mem_load_op_q  <= '0;
      mem_addr_lo_q  <= '0;
    end else if (bus.flush_i) begin
      mem_valid_q    <= 1'b0;
      mem_pc_q       <= '0;
      mem_rf_we_q    <= 1'b0;
      mem_rf_waddr_q <= '0;
      mem_result_q   <= '0;
      mem_load_op_q  <= '0;
      mem_addr_lo_q  <= '0;
    end else if (!bus.stall_i) begin
      mem_valid_q    <= bus.ex_valid;
      mem_pc_q       <= bus.ex_pc;
      mem_rf_we_q    <= bus.ex_rf_we;
      mem_rf_waddr_q <= bus.ex_rf_waddr;
      mem_result_q   <= bus.ex_result;
      mem_load_op_q  <= bus.ex_load_op;
      mem_addr_lo_q  <= bus.ex_result[1:0];
    end
  end

  // fresh marks the first cycle an entry occupies MEM (the only cycle rdata is valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh_q <= 1'b0;
    end else begin
      fresh_q <= load_en;
    end
  end

  // Read-data buffer: keep the SRAM word when a load's first MEM cycle is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else if (bus.flush_i || !bus.stall_i) begin
      buf_valid_q <= 1'b0;
    end else if (mem_valid_q && (mem_load_op_q != 3'd0) && fresh_q) begin
      buf_q       <= bus.data_sram_rdata;
      buf_valid_q <= 1'b1;
    end
  end

  // Load data selection and alignment.
  always_comb begin
    raw_data = buf_valid_q ? buf_q : bus.data_sram_rdata;
    ld_byte  = raw_data[7:0];
    case (mem_addr_lo_q)
      2'd0:    ld_byte = raw_data[7:0];
      2'd1:    ld_byte = raw_data[15:8];
      2'd2:    ld_byte = raw_data[23:16];
      default: ld_byte = raw_data[31:24];
    endcase
    ld_half = mem_addr_lo_q[1] ? raw_data[31:16] : raw_data[15:0];
    aligned = mem_result_q;
    case (mem_load_op_q)
      LdLb:    aligned = {{24{ld_byte[7]}}, ld_byte};
      LdLbu:   aligned = {24'h0, ld_byte};
      LdLh:    aligned = {{16{ld_half[15]}}, ld_half};
      LdLhu:   aligned = {16'h0, ld_half};
      LdLw:    aligned = raw_data;
      default: aligned = mem_result_q;
    endcase
  end

  assign adel = mem_valid_q &
                ((((mem_load_op_q == LdLh) || (mem_load_op_q == LdLhu)) && mem_addr_lo_q[0]) ||
                 ((mem_load_op_q == LdLw) && (mem_addr_lo_q != 2'd0)));

  assign we_eff = mem_valid_q & mem_rf_we_q & ~adel;

  assign bus.wb_valid    = mem_valid_q & ~bus.stall_i;
  assign bus.wb_pc       = mem_pc_q;
  assign bus.wb_rf_we    = we_eff & ~bus.stall_i;
  assign bus.wb_rf_waddr = mem_rf_waddr_q;
  assign bus.wb_rf_wdata = aligned;
  assign bus.mem_adel    = adel;
  // Bypass stays live during a stall so ID can still forward the pending write.
  assign bus.mem_to_id   = {we_eff, mem_rf_waddr_q, aligned};

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` and `rst_n`.
REQ-002 `clk`  in  1  rising-edge clock for all state.
REQ-003 `rst_n`  in  1  asynchronous, active-low reset; clears all state.
REQ-004 `stall_i`  in  1  holds the MEM register; sends a bubble to WB.
REQ-005 `flush_i`  in  1  kills the instruction in MEM at the next edge.
REQ-006 `ex_valid`  in  1  EX holds a valid instruction.
REQ-007 `ex_pc`  in  32  PC of the EX instruction.
REQ-008 `ex_rf_we`  in  1  register-write enable.
REQ-009 `ex_rf_waddr`  in  5  destination register.
REQ-010 `ex_result`  in  32  ALU result or effective address.
REQ-011 `ex_load_op`  in  3  load type: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw; codes 6 and 7 are treated as none.
REQ-012 `data_sram_rdata`  in  32  SRAM read data; valid only in the first cycle a load occupies MEM.
REQ-013 `wb_valid`  out  1  valid instruction to WB.
REQ-014 `wb_pc`  out  32  PC to WB.
REQ-015 `wb_rf_we`  out  1  write enable to WB.
REQ-016 `wb_rf_waddr`  out  5  destination register to WB.
REQ-017 `wb_rf_wdata`  out  32  write data to WB.
REQ-018 `mem_adel`  out  1  misaligned-load exception for the instruction in MEM.
REQ-019 `mem_to_id`  out  38  bypass bus {we[37], waddr[36:32], wdata[31:0]} for the register file.

Function
REQ-020 The MEM register (valid, pc, rf_we, rf_waddr, result, load_op, addr_lo = ex_result[1:0]) SHALL load from the EX inputs at each rising edge where stall_i=0 and flush_i=0.
REQ-021 Edge with flush_i=1: mem valid SHALL clear, regardless of stall_i (flush has priority).
REQ-022 Edge with stall_i=1 and flush_i=0: the MEM register SHALL hold all fields.
REQ-023 Latency: EX inputs sampled at edge N SHALL appear on the WB outputs and mem_to_id during cycle N+1 (combinational from the MEM register).
REQ-024 A `fresh` flag SHALL be set at any edge that loads the MEM register, and SHALL clear at any other edge.
REQ-025 Read-data buffer:
- When mem valid=1, load_op is nonzero, fresh=1 and stall_i=1, the block SHALL capture data_sram_rdata into buf and set buf_valid=1.
- buf_valid SHALL clear at any edge with stall_i=0 or flush_i=1.
REQ-026 Raw load data SHALL be buf when buf_valid=1, otherwise data_sram_rdata.
REQ-027 Load alignment (byte k = addr_lo):
- lb: byte k, sign-extended.
- lbu: byte k, zero-extended.
- lh: halfword addr_lo[1] (bits 15:0 or 31:16), sign-extended.
- lhu: same halfword, zero-extended.
- lw: full word.
- none: result.
REQ-028 mem_adel SHALL be 1 when mem valid=1 and either of these holds; otherwise 0:
- (lh or lhu) and addr_lo[0]=1;
- lw and addr_lo≠0.
REQ-029 Effective write enable `we_eff` SHALL equal mem valid & rf_we & ~mem_adel.
REQ-030 wb_valid SHALL equal mem valid & ~stall_i.
REQ-031 wb_rf_we SHALL equal we_eff & ~stall_i.
REQ-032 wb_pc, wb_rf_waddr and wb_rf_wdata SHALL always reflect the MEM register and the aligned data.
REQ-033 mem_to_id SHALL be {we_eff, rf_waddr, aligned data}, and SHALL remain valid while stalled.
REQ-034 A flush and a stall asserted on the same edge SHALL clear both mem valid and buf_valid.
REQ-035 Repeated stall cycles SHALL return buf contents unchanged; data_sram_rdata changes during a stall SHALL be ignored.

Reset
REQ-036 While rst_n=0, every register SHALL be 0 (mem valid, fresh, buf, buf_valid and all MEM fields).
REQ-037 While rst_n=0, every output SHALL be 0, including mem_to_id=38'h0.
REQ-038 Reset asserted mid-stall SHALL discard any buffered data.
REQ-039 After reset release, the first valid output SHALL occur one cycle after the first sampled ex_valid=1.

Verification
REQ-040 ALU pass-through: ex_valid=1, rf_we=1, waddr=5, result=0x1234 -> next cycle: wb_valid=1, wb_rf_wdata=0x1234, mem_to_id={1,5,0x1234}.
REQ-041 Byte load: lb, addr_lo=3, rdata=0x80FF_0000 -> wb_rf_wdata=0xFFFF_FF80.
REQ-042 Halfword load: lhu, addr_lo=2, same rdata -> wb_rf_wdata=0x0000_80FF.
REQ-043 Stall buffering: lw, rdata=0xA5A5_A5A5 with stall_i=1 for 3 cycles and rdata changed to 0 after cycle 1 -> mem_to_id data stays 0xA5A5_A5A5; wb_valid=0 for 3 cycles, then 1 for one cycle.
REQ-044 Misaligned load: lw, addr_lo=2 -> mem_adel=1, wb_rf_we=0, mem_to_id[37]=0; lh, addr_lo=2 -> mem_adel=0.
REQ-045 Flush priority: flush_i=1 and stall_i=1 on the same edge with a valid load in MEM -> next cycle wb_valid=0 and mem_to_id=38'h0.
REQ-046 Async reset: rst_n pulsed low between edges during a stall -> all outputs read 0 immediately, with no edge required.
